dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 13, the byte-address width; the array holds 2^(ADDR_W-2) 32-bit words.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, reset, asynchronous and active-high.
REQ-004 The block SHALL have port DM_CS, input, 1, chip select; no access occurs when low.
REQ-005 The block SHALL have port DM_R, input, 1, read enable.
REQ-006 The block SHALL have port DM_W, input, 1, write enable.
REQ-007 The block SHALL have port DM_bit, input, 2, access size: 00 word, 01 halfword, 10 byte, 11 invalid.
REQ-008 The block SHALL have port addr, input, ADDR_W, the byte address.
REQ-009 The block SHALL have port wdata, input, 32, store data, right-aligned for halfword and byte.
REQ-010 The block SHALL have port rdata, output, 32, load data, right-aligned and zero-extended.
REQ-011 The block SHALL have port busy, output, 1, high while the post-reset clear sweep runs.
REQ-012 The block SHALL have port err, output, 1, sticky flag for a misaligned or invalid access.

Function
REQ-013 FSM states SHALL be CLEAR and READY; reset forces CLEAR with clear counter = 0.
REQ-014 In CLEAR, each rising edge SHALL write 32'h0 to word[counter] and increment the counter.
REQ-015 When counter = last word index, CLEAR SHALL write that word and go to READY on the same edge; the sweep takes exactly 2^(ADDR_W-2) cycles.
REQ-016 busy SHALL be 1 in CLEAR and 0 in READY.
REQ-017 In CLEAR, CPU writes SHALL be dropped, rdata SHALL be 0, and err SHALL NOT be set.
REQ-018 A read SHALL be combinational: in READY, when DM_CS=1 and DM_R=1, rdata reflects the array in the same cycle; otherwise rdata = 0.
REQ-019 Word read SHALL return word[addr[ADDR_W-1:2]].
REQ-020 Halfword read SHALL return bits [31:16] when addr[1]=1, else [15:0], in rdata[15:0], with the upper bits 0.
REQ-021 Byte read SHALL return the lane selected by addr[1:0] (0 = bits [7:0], little-endian), in rdata[7:0], with the upper bits 0.
REQ-022 A write SHALL occur on the rising edge when READY, DM_CS=1 and DM_W=1, and SHALL modify only the addressed lanes.
REQ-023 A halfword write SHALL modify 2 bytes and a byte write 1 byte; the other bytes of the word are preserved.
REQ-024 When a write and a read address the same word in the same cycle, rdata SHALL show the pre-write contents; the new value is visible from the next cycle.
REQ-025 Misalignment SHALL be defined as: word access with addr[1:0]!=0, halfword access with addr[0]=1, or DM_bit=11.
REQ-026 A misaligned access with DM_CS=1 and (DM_R or DM_W) SHALL suppress the write and force rdata = 0.
REQ-027 Such an access SHALL set err on the next rising edge; err stays 1 until reset.
REQ-028 DM_R=1 and DM_W=1 together SHALL be legal: write per REQ-022, read per REQ-024.
REQ-029 addr bits above ADDR_W do not exist; no wrap logic is needed beyond the ADDR_W width.

Reset
REQ-030 Asserting reset at any time, including mid-sweep, SHALL immediately set the state to CLEAR, counter = 0, busy = 1 and err = 0.
REQ-031 An in-progress sweep interrupted by reset SHALL restart from word 0.
REQ-032 Array contents are not reset directly; they are guaranteed 0 only once busy falls.

Verification
REQ-033 Release reset with ADDR_W=13 -> busy=1 for exactly 2048 cycles, then 0; a word read of any address, e.g. 0x1FFC, returns 0.
REQ-034 Word write 0x11223344 at 0x010, then byte write 0xAA at 0x011 and halfword write 0xBEEF at 0x012 -> word read at 0x010 returns 0xBEEFAA44; byte read at 0x013 returns 0x000000BE.
REQ-035 Same-cycle write 0xDEADBEEF and read at 0x020, which holds 0 -> rdata=0 that cycle and 0xDEADBEEF the next cycle.
REQ-036 Word write at 0x006 -> no array change and err=1 from the next edge; a later valid access leaves err=1; reset clears it.
REQ-037 Assert reset at clear cycle 1000, then release -> busy stays high for a full 2048 further cycles; write attempts during busy are not retained.
REQ-038 DM_CS=0 with DM_W=1 at 0x040 -> contents unchanged, rdata=0 and err unchanged.

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder: word-organised data memory with byte/halfword/word access.
// After reset the whole array is swept to zero, one word per clock, while
// busy is high; CPU accesses are ignored until the sweep finishes.
//
// Ports:
//   clk    - single clock, all state updates on its rising edge
//   reset  - asynchronous active-high reset (restarts the clear sweep)
//   DM_CS  - chip select; no access when low
//   DM_R   - read enable (combinational read path)
//   DM_W   - write enable (write on rising edge)
//   DM_bit - access size: 00 word, 01 halfword, 10 byte, 11 invalid
//   addr   - byte address
//   wdata  - store data, right-aligned for halfword/byte
//   rdata  - load data, right-aligned and zero-extended
//   busy   - high while the clear sweep runs
//   err    - sticky flag for a misaligned or invalid access
module dmem_responder #(
  parameter int ADDR_W = 13
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              DM_CS,
  input  logic              DM_R,
  input  logic              DM_W,
  input  logic [1:0]        DM_bit,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              busy,
  output logic              err
);

  localparam int WORD_AW = ADDR_W - 2;
  localparam int WORDS   = 1 << WORD_AW;

  typedef enum logic {
    CLEAR,
    READY
  } state_t;

  state_t               state;
  logic [WORD_AW-1:0]   clr_cnt;
  logic [31:0]          mem [WORDS];

  logic [WORD_AW-1:0]   word_idx;
  logic [1:0]           lane;
  logic                 misalign;
  logic                 ready;
  logic                 wr_en;
  logic                 rd_en;
  logic [3:0]           byte_en;
  logic [31:0]          wr_word;
  logic [31:0]          rd_word;

  assign word_idx = addr[ADDR_W-1:2];
  assign lane     = addr[1:0];
  assign ready    = (state == READY);

  always_comb begin
    misalign = 1'b0;
    case (DM_bit)
      2'b00:   misalign = (lane != 2'b00);
      2'b01:   misalign = lane[0];
      2'b10:   misalign = 1'b0;
      default: misalign = 1'b1;
    endcase
  end

  assign wr_en = ready && DM_CS && DM_W && !misalign;
  assign rd_en = ready && DM_CS && DM_R && !misalign;

  // Store data is replicated onto the lanes it may occupy; byte_en picks
  // which lanes actually get written.
  always_comb begin
    byte_en = '0;
    wr_word = '0;
    case (DM_bit)
      2'b00: begin
        byte_en = 4'b1111;
        wr_word = wdata;
      end
      2'b01: begin
        byte_en = lane[1] ? 4'b1100 : 4'b0011;
        wr_word = {2{wdata[15:0]}};
      end
      2'b10: begin
        byte_en = 4'b0001 << lane;
        wr_word = {4{wdata[7:0]}};
      end
      default: begin
        byte_en = '0;
        wr_word = '0;
      end
    endcase
  end

  // Array storage has no reset; the CLEAR sweep zeroes it instead.
  // While reset is held the FSM sits in CLEAR with counter 0, so word 0 is
  // simply rewritten with zero, which is harmless.
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[clr_cnt] <= '0;
    end else if (wr_en) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (byte_en[i]) begin
          mem[word_idx][8*i +: 8] <= wr_word[8*i +: 8];
        end
      end
    end
  end

  // Combinational read returns the pre-write word when read and write hit
  // the same location in one cycle.
  assign rd_word = mem[word_idx];

  always_comb begin
    rdata = '0;
    if (rd_en) begin
      case (DM_bit)
        2'b00: rdata = rd_word;
        2'b01: rdata = {16'h0, (lane[1] ? rd_word[31:16] : rd_word[15:0])};
        2'b10: begin
          case (lane)
            2'b00:   rdata = {24'h0, rd_word[7:0]};
            2'b01:   rdata = {24'h0, rd_word[15:8]};
            2'b10:   rdata = {24'h0, rd_word[23:16]};
            default: rdata = {24'h0, rd_word[31:24]};
          endcase
        end
        default: rdata = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= CLEAR;
      clr_cnt <= '0;
      busy    <= 1'b1;
      err     <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          clr_cnt <= clr_cnt + 1'b1;
          if (clr_cnt == '1) begin
            state <= READY;
            busy  <= 1'b0;
          end
        end
        READY: begin
          if (DM_CS && (DM_R || DM_W) && misalign) begin
            err <= 1'b1;
          end
        end
        default: begin
          state <= CLEAR;
          busy  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios plus a
// randomized access mix checked against a behavioural memory model.
module tb_dmem_responder;

  localparam int AW = 13;
  localparam int NW = 2048;

  logic          clk = 1'b0;
  logic          reset;
  logic          cs, rd, wr;
  logic [1:0]    sz;
  logic [AW-1:0] addr;
  logic [31:0]   wdata;
  logic [31:0]   rdata;
  logic          busy;
  logic          err;

  int errors = 0;
  int checks = 0;

  logic [31:0] model [NW];
  bit          err_m;

  dmem_responder #(.ADDR_W(AW)) dut (
    .clk    (clk),
    .reset  (reset),
    .DM_CS  (cs),
    .DM_R   (rd),
    .DM_W   (wr),
    .DM_bit (sz),
    .addr   (addr),
    .wdata  (wdata),
    .rdata  (rdata),
    .busy   (busy),
    .err    (err)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic bit is_bad(input logic [1:0] s, input logic [1:0] off);
    return (s == 2'd3) || (s == 2'd0 && off != 2'd0) || (s == 2'd1 && off[0]);
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] w, input logic [1:0] s,
                                           input logic [1:0] off);
    int sh;
    logic [31:0] r;
    sh = 8 * int'(off);
    case (s)
      2'd0:    r = w;
      2'd1:    r = (w >> sh) & 32'h0000_FFFF;
      2'd2:    r = (w >> sh) & 32'h0000_00FF;
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [1:0] s, input logic [1:0] off);
    int sh;
    logic [31:0] mask;
    sh = 8 * int'(off);
    case (s)
      2'd0:    mask = 32'hFFFF_FFFF;
      2'd1:    mask = 32'h0000_FFFF << sh;
      default: mask = 32'h0000_00FF << sh;
    endcase
    return (old & ~mask) | ((wd << sh) & mask);
  endfunction

  // Apply the currently driven access to the model (called just before the edge).
  task automatic model_step();
    if (busy == 1'b0 && cs && (rd || wr)) begin
      if (is_bad(sz, addr[1:0])) err_m = 1'b1;
      else if (wr) model[addr[AW-1:2]] = merge(model[addr[AW-1:2]], wdata, sz, addr[1:0]);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NW; i++) model[i] = 32'h0;
    err_m = 1'b0;
  endtask

  task automatic idle();
    cs = 1'b0; rd = 1'b0; wr = 1'b0; sz = 2'd0; addr = '0; wdata = 32'h0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic c, input logic r, input logic w, input logic [1:0] s,
                       input logic [AW-1:0] a, input logic [31:0] d);
    cs = c; rd = r; wr = w; sz = s; addr = a; wdata = d;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    int n;
    idle();
    reset = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 2'd0, 13'h0, 32'h0);
    #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy got=%b exp=1", busy); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", err); end
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
    tick(); tick();
    reset = 1'b0;
    // misaligned access during the sweep must not set err
    drive(1'b1, 1'b1, 1'b1, 2'd3, 13'h0006, 32'hFFFF_FFFF);
    n = 0;
    while (busy === 1'b1 && n < 5000) begin tick(); n++; end
    checks++; if (n != NW) begin errors++; $display("FAIL sweep_len got=%0d exp=%0d", n, NW); end
    idle();
    model_clear();
    drive(1'b1, 1'b1, 1'b0, 2'd0, 13'h1FFC, 32'h0);
    #1;
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL read_1ffc got=%h exp=0", rdata); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_after_sweep got=%b exp=0", err); end
    tick();
    idle();
  endtask

  task automatic test_lanes();
    drive(1'b1, 1'b0, 1'b1, 2'd0, 13'h010, 32'h1122_3344); model_step(); tick();
    drive(1'b1, 1'b0, 1'b1, 2'd2, 13'h011, 32'h0000_00AA); model_step(); tick();
    drive(1'b1, 1'b0, 1'b1, 2'd1, 13'h012, 32'h0000_BEEF); model_step(); tick();
    drive(1'b1, 1'b1, 1'b0, 2'd0, 13'h010, 32'h0);
    #1;
    checks++; if (rdata !== 32'hBEEF_AA44) begin errors++; $display("FAIL lane_word got=%h exp=beefaa44", rdata); end
    drive(1'b1, 1'b1, 1'b0, 2'd2, 13'h013, 32'h0);
    #1;
    checks++; if (rdata !== 32'h0000_00BE) begin errors++; $display("FAIL lane_byte3 got=%h exp=000000be", rdata); end
    drive(1'b1, 1'b1, 1'b0, 2'd1, 13'h010, 32'h0);
    #1;
    checks++; if (rdata !== 32'h0000_AA44) begin errors++; $display("FAIL lane_half0 got=%h exp=0000aa44", rdata); end
    tick();
    idle();
  endtask

  task automatic test_same_cycle();
    drive(1'b1, 1'b1, 1'b1, 2'd0, 13'h020, 32'hDEAD_BEEF);
    #1;
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL same_cycle_old got=%h exp=0", rdata); end
    model_step(); tick();
    wr = 1'b0;
    #1;
    checks++; if (rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL same_cycle_new got=%h exp=deadbeef", rdata); end
    tick();
    idle();
  endtask

  task automatic test_cs_low();
    logic e0;
    e0 = err;
    drive(1'b0, 1'b1, 1'b1, 2'd0, 13'h040, 32'hCAFE_F00D);
    #1;
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL cs_low_rdata got=%h exp=0", rdata); end
    model_step(); tick();
    checks++; if (err !== e0) begin errors++; $display("FAIL cs_low_err got=%b exp=%b", err, e0); end
    drive(1'b1, 1'b1, 1'b0, 2'd0, 13'h040, 32'h0);
    #1;
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL cs_low_mem got=%h exp=0", rdata); end
    tick();
    idle();
  endtask

  task automatic test_misalign();
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL mis_err_pre got=%b exp=0", err); end
    drive(1'b1, 1'b1, 1'b1, 2'd0, 13'h006, 32'h1234_5678);
    #1;
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL mis_rdata got=%h exp=0", rdata); end
    model_step(); tick();
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL mis_err_set got=%b exp=1", err); end
    drive(1'b1, 1'b1, 1'b0, 2'd0, 13'h004, 32'h0);
    #1;
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL mis_no_write got=%h exp=0", rdata); end
    model_step(); tick();
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL mis_err_sticky got=%b exp=1", err); end
    idle();
  endtask

  task automatic test_random();
    logic [31:0] exp;
    for (int k = 0; k < 400; k++) begin
      cs    = ($urandom_range(0, 7) != 0);
      rd    = 1'($urandom_range(0, 1));
      wr    = 1'($urandom_range(0, 1));
      sz    = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      addr  = 13'($urandom_range(0, 255));
      wdata = $urandom;
      #1;
      exp = (cs && rd && !is_bad(sz, addr[1:0])) ? ref_read(model[addr[AW-1:2]], sz, addr[1:0]) : 32'h0;
      checks++; if (rdata !== exp) begin errors++; $display("FAIL rand_rdata[%0d] got=%h exp=%h", k, rdata, exp); end
      model_step(); tick();
      checks++; if (err !== err_m) begin errors++; $display("FAIL rand_err[%0d] got=%b exp=%b", k, err, err_m); end
    end
    for (int w = 0; w < 64; w++) begin
      drive(1'b1, 1'b1, 1'b0, 2'd0, 13'(w * 4), 32'h0);
      #1;
      checks++; if (rdata !== model[w]) begin errors++; $display("FAIL rand_dump[%0d] got=%h exp=%h", w, rdata, model[w]); end
    end
    idle();
    tick();
  endtask

  task automatic test_reset_mid_sweep();
    int n;
    reset = 1'b1;
    #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_busy got=%b exp=1", busy); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err_clear got=%b exp=0", err); end
    tick();
    reset = 1'b0;
    drive(1'b1, 1'b0, 1'b1, 2'd0, 13'h100, 32'h5A5A_5A5A);
    for (int i = 0; i < 1000; i++) tick();
    reset = 1'b1;
    #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_rst_busy got=%b exp=1", busy); end
    tick();
    reset = 1'b0;
    drive(1'b1, 1'b0, 1'b1, 2'd0, 13'h000, 32'hA5A5_A5A5);
    n = 0;
    while (busy === 1'b1 && n < 5000) begin tick(); n++; end
    checks++; if (n != NW) begin errors++; $display("FAIL mid_sweep_len got=%0d exp=%0d", n, NW); end
    idle();
    model_clear();
    drive(1'b1, 1'b1, 1'b0, 2'd0, 13'h100, 32'h0);
    #1;
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL mid_drop_100 got=%h exp=0", rdata); end
    drive(1'b1, 1'b1, 1'b0, 2'd0, 13'h000, 32'h0);
    #1;
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL mid_drop_000 got=%h exp=0", rdata); end
    drive(1'b1, 1'b1, 1'b0, 2'd0, 13'h010, 32'h0);
    #1;
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL mid_cleared_010 got=%h exp=0", rdata); end
    tick();
    idle();
  endtask

  initial begin
    err_m = 1'b0;
    test_reset();
    test_lanes();
    test_same_cycle();
    test_cs_low();
    test_misalign();
    test_random();
    test_reset_mid_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
